icache_responder: RTL and testbench

Instruction-cache responder serving the fetch-side instruction buffer. Each cycle it takes the buffer's fetch request (PC plus instruction count) and returns up to `N_WAY` consecutive instructions, along with their addresses, per-lane valid bits and a hit count. Lookup uses a direct-mapped array of 64-bit lines. Misses are fetched from the tagged memory interface by a single-outstanding-miss FSM.

---
 rtl/icache_responder_if.sv | 38 +++
 rtl/icache_responder.sv | 152 +++++++++++++++
 tb/tb_icache_responder.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_responder_if.sv
// Fetch-side bus of the instruction-cache responder.
//   Buffer side : buff2Icache_addr/count (request), Icache2buff_addr/data/valid/hit_count
//                 (combinational response).
//   Memory side : proc2mem_command/addr (miss request), mem2proc_response (accept tag),
//                 mem2proc_data/tag (returned block).
// Modport slave is the cache; modport master is whoever drives requests and memory.
interface icache_responder_if #(
  parameter int unsigned N_WAY = 3,
  parameter int unsigned XLEN  = 32
);
  localparam int unsigned CNT_W = $clog2(N_WAY) + 1;

  logic [XLEN-1:0]             buff2Icache_addr;
  logic [CNT_W-1:0]            buff2Icache_count;
  logic [N_WAY-1:0][XLEN-1:0]  Icache2buff_addr;
  logic [N_WAY-1:0][XLEN-1:0]  Icache2buff_data;
  logic [N_WAY-1:0]            Icache2buff_valid;
  logic [CNT_W-1:0]            Icache2buff_hit_count;
  logic [1:0]                  proc2mem_command;
  logic [XLEN-1:0]             proc2mem_addr;
  logic [3:0]                  mem2proc_response;
  logic [63:0]                 mem2proc_data;
  logic [3:0]                  mem2proc_tag;

  modport slave (
    input  buff2Icache_addr, buff2Icache_count,
    input  mem2proc_response, mem2proc_data, mem2proc_tag,
    output Icache2buff_addr, Icache2buff_data, Icache2buff_valid, Icache2buff_hit_count,
    output proc2mem_command, proc2mem_addr
  );

  modport master (
    output buff2Icache_addr, buff2Icache_count,
    output mem2proc_response, mem2proc_data, mem2proc_tag,
    input  Icache2buff_addr, Icache2buff_data, Icache2buff_valid, Icache2buff_hit_count,
    input  proc2mem_command, proc2mem_addr
  );
endinterface

// File: rtl/icache_responder.sv
// Instruction-cache responder: direct-mapped array of 64-bit lines (two instructions each).
// Returns up to N_WAY consecutive instructions from the request PC in the same cycle, with a
// valid prefix and hit count. A single-outstanding-miss FSM fetches the first missing block.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset (clears line valid bits and the FSM)
//   bus   : icache_responder_if.slave (buffer request/response and memory interface)
module icache_responder #(
  parameter int unsigned N_WAY     = 3,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NUM_LINES = 32
) (
  input logic               clock,
  input logic               reset,
  icache_responder_if.slave bus
);
  localparam int unsigned IDX_W  = $clog2(NUM_LINES);
  localparam int unsigned TAG_W  = XLEN - 3 - IDX_W;
  localparam int unsigned CNT_W  = $clog2(N_WAY) + 1;
  localparam int unsigned WORD_W = XLEN - 2;

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  // Line storage; only the valid bits need reset.
  logic [NUM_LINES-1:0] line_valid_q;
  logic [TAG_W-1:0]     line_tag_q  [NUM_LINES];
  logic [63:0]          line_data_q [NUM_LINES];

  state_e          state_q;
  logic [1:0]      command_q;
  logic [XLEN-1:0] mem_addr_q;  // also the block being filled while in StWait
  logic [3:0]      mem_tag_q;

  logic [WORD_W-1:0]          pc_word;
  logic [CNT_W-1:0]           req_count;
  logic [N_WAY-1:0]           lane_hit;
  logic [N_WAY-1:0]           lane_valid;
  logic [N_WAY-1:0][XLEN-1:0] lane_addr;
  logic [N_WAY-1:0][XLEN-1:0] lane_block;
  logic [N_WAY-1:0][XLEN-1:0] lane_data;
  logic [N_WAY-1:0][XLEN-1:0] lane_out_data;
  logic [CNT_W-1:0]           hit_count;
  logic                       prefix_ok;
  logic                       miss_found;
  logic [XLEN-1:0]            miss_addr;
  logic                       fill_en;
  logic [IDX_W-1:0]           fill_idx;
  logic [TAG_W-1:0]           fill_tag;
  logic                       unused_pc_bits;

  // Byte offset within an instruction is meaningless for fetch.
  assign unused_pc_bits = ^bus.buff2Icache_addr[1:0];
  assign pc_word        = bus.buff2Icache_addr[XLEN-1:2];
  assign req_count      = (bus.buff2Icache_count > CNT_W'(N_WAY)) ? CNT_W'(N_WAY)
                                                                  : bus.buff2Icache_count;

  // Each lane looks up independently; word arithmetic wraps modulo 2^XLEN.
  for (genvar g = 0; g < N_WAY; g++) begin : g_lane
    logic [WORD_W-1:0] word;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;

    assign word          = pc_word + WORD_W'(g);
    assign idx           = word[IDX_W:1];
    assign tag           = word[WORD_W-1:IDX_W+1];
    assign lane_hit[g]   = line_valid_q[idx] && (line_tag_q[idx] == tag);
    assign lane_addr[g]  = {word, 2'b00};
    assign lane_block[g] = {word[WORD_W-1:1], 3'b000};
    assign lane_data[g]  = word[0] ? line_data_q[idx][63:32] : line_data_q[idx][31:0];
  end

  always_comb begin
    lane_valid    = '0;
    lane_out_data = '0;
    hit_count     = '0;
    prefix_ok     = 1'b1;
    miss_found    = 1'b0;
    miss_addr     = '0;
    for (int i = 0; i < N_WAY; i++) begin
      // Valid lanes form a prefix: one miss invalidates every later lane.
      prefix_ok     = prefix_ok && (CNT_W'(i) < req_count) && lane_hit[i];
      lane_valid[i] = prefix_ok;
      if (prefix_ok) begin
        lane_out_data[i] = lane_data[i];
      end
      hit_count = hit_count + CNT_W'(lane_valid[i]);
      if (!miss_found && (CNT_W'(i) < req_count) && !lane_hit[i]) begin
        miss_found = 1'b1;
        miss_addr  = lane_block[i];
      end
    end
  end

  assign bus.Icache2buff_addr      = lane_addr;
  assign bus.Icache2buff_data      = lane_out_data;
  assign bus.Icache2buff_valid     = lane_valid;
  assign bus.Icache2buff_hit_count = hit_count;
  assign bus.proc2mem_command      = command_q;
  assign bus.proc2mem_addr         = mem_addr_q;

  assign fill_en  = (state_q == StWait) && (bus.mem2proc_tag == mem_tag_q);
  assign fill_idx = mem_addr_q[3+IDX_W-1:3];
  assign fill_tag = mem_addr_q[XLEN-1:3+IDX_W];

  // Miss FSM with registered memory-side outputs; LOAD is driven only in StReq.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      command_q    <= 2'd0;
      mem_addr_q   <= '0;
      mem_tag_q    <= '0;
      line_valid_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (miss_found) begin
            mem_addr_q <= miss_addr;
            command_q  <= 2'd1;
            state_q    <= StReq;
          end
        end
        StReq: begin
          // A zero response means memory rejected the LOAD; keep issuing it.
          if (bus.mem2proc_response != 4'd0) begin
            mem_tag_q <= bus.mem2proc_response;
            command_q <= 2'd0;
            state_q   <= StWait;
          end
        end
        StWait: begin
          // Fill is never cancelled; it evicts whatever occupies the index.
          if (fill_en) begin
            line_valid_q[fill_idx] <= 1'b1;
            state_q                <= StIdle;
          end
        end
        default: begin
          command_q <= 2'd0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

  // Tag/data storage is gated by the valid bits and needs no reset.
  always_ff @(posedge clock) begin
    if (fill_en) begin
      line_tag_q[fill_idx]  <= fill_tag;
      line_data_q[fill_idx] <= bus.mem2proc_data;
    end
  end

endmodule

// File: tb/tb_icache_responder.sv
module tb_icache_responder;
  logic clock;
  logic reset;
  int   checks;
  int   errors;

  icache_responder_if #(.N_WAY(3), .XLEN(32)) bus ();

  icache_responder #(
    .N_WAY    (3),
    .XLEN     (32),
    .NUM_LINES(32)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_dut();
    bus.buff2Icache_count = 3'd0;
    bus.mem2proc_response = 4'd0;
    bus.mem2proc_tag      = 4'd0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // Miss on addr, accept with tag t, return the block.
  task automatic fill_line(input logic [31:0] addr, input logic [63:0] data,
                           input logic [3:0] t);
    bus.buff2Icache_addr  = addr;
    bus.buff2Icache_count = 3'd1;
    tick();
    bus.mem2proc_response = t;
    tick();
    bus.mem2proc_response = 4'd0;
    bus.mem2proc_tag      = t;
    bus.mem2proc_data     = data;
    tick();
    bus.mem2proc_tag      = 4'd0;
  endtask

  task automatic test_reset();
    bus.buff2Icache_addr  = 32'h0;
    bus.buff2Icache_count = 3'd3;
    tick();
    tick();
    checks++;
    if (bus.Icache2buff_valid !== 3'b000) begin
      errors++; $display("FAIL reset_valid got %b want 000", bus.Icache2buff_valid);
    end
    checks++;
    if (bus.Icache2buff_hit_count !== 3'd0) begin
      errors++; $display("FAIL reset_hit_count got %0d want 0", bus.Icache2buff_hit_count);
    end
    checks++;
    if (bus.proc2mem_command !== 2'd0 || bus.proc2mem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_mem got cmd %0d addr %h want 0 0",
                         bus.proc2mem_command, bus.proc2mem_addr);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (bus.proc2mem_command !== 2'd1 || bus.proc2mem_addr !== 32'h0) begin
      errors++; $display("FAIL first_load got cmd %0d addr %h want 1 00000000",
                         bus.proc2mem_command, bus.proc2mem_addr);
    end
  endtask

  task automatic test_cold_fill();
    bus.mem2proc_response = 4'd2;
    tick();
    bus.mem2proc_response = 4'd0;
    checks++;
    if (bus.proc2mem_command !== 2'd0) begin
      errors++; $display("FAIL wait_cmd got %0d want 0", bus.proc2mem_command);
    end
    bus.mem2proc_tag  = 4'd2;
    bus.mem2proc_data = 64'h00500093_00100013;
    #1;
    checks++;
    if (bus.Icache2buff_valid !== 3'b000) begin
      errors++; $display("FAIL no_bypass got %b want 000", bus.Icache2buff_valid);
    end
    tick();
    bus.mem2proc_tag = 4'd0;
    #1;
    checks++;
    if (bus.Icache2buff_valid !== 3'b011 || bus.Icache2buff_hit_count !== 3'd2) begin
      errors++; $display("FAIL fill_valid got %b/%0d want 011/2",
                         bus.Icache2buff_valid, bus.Icache2buff_hit_count);
    end
    checks++;
    if (bus.Icache2buff_data[0] !== 32'h00100013 || bus.Icache2buff_data[1] !== 32'h00500093) begin
      errors++; $display("FAIL fill_data got %h %h want 00100013 00500093",
                         bus.Icache2buff_data[0], bus.Icache2buff_data[1]);
    end
    checks++;
    if (bus.Icache2buff_addr[1] !== 32'h4 || bus.Icache2buff_addr[2] !== 32'h8 ||
        bus.Icache2buff_data[2] !== 32'h0) begin
      errors++; $display("FAIL lane_addr got %h %h data2 %h want 4 8 0",
                         bus.Icache2buff_addr[1], bus.Icache2buff_addr[2],
                         bus.Icache2buff_data[2]);
    end
    tick();
    checks++;
    if (bus.proc2mem_command !== 2'd1 || bus.proc2mem_addr !== 32'h8) begin
      errors++; $display("FAIL second_load got cmd %0d addr %h want 1 00000008",
                         bus.proc2mem_command, bus.proc2mem_addr);
    end
  endtask

  task automatic test_mem_busy();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.proc2mem_command !== 2'd1 || bus.proc2mem_addr !== 32'h8 ||
          bus.Icache2buff_valid !== 3'b011) begin
        errors++; $display("FAIL busy_hold%0d got cmd %0d addr %h valid %b want 1 8 011", k,
                           bus.proc2mem_command, bus.proc2mem_addr, bus.Icache2buff_valid);
      end
      tick();
    end
    bus.mem2proc_response = 4'd5;
    #1;
    checks++;
    if (bus.proc2mem_command !== 2'd1 || bus.proc2mem_addr !== 32'h8) begin
      errors++; $display("FAIL busy_fourth got cmd %0d addr %h want 1 8",
                         bus.proc2mem_command, bus.proc2mem_addr);
    end
    tick();
    bus.mem2proc_response = 4'd0;
    checks++;
    if (bus.proc2mem_command !== 2'd0) begin
      errors++; $display("FAIL busy_wait got cmd %0d want 0", bus.proc2mem_command);
    end
    bus.mem2proc_tag  = 4'd3;
    bus.mem2proc_data = 64'hdeadbeef_deadbeef;
    tick();
    bus.mem2proc_tag = 4'd4;
    tick();
    bus.mem2proc_tag = 4'd0;
    #1;
    checks++;
    if (bus.Icache2buff_valid !== 3'b011) begin
      errors++; $display("FAIL wrong_tag got valid %b want 011", bus.Icache2buff_valid);
    end
    bus.mem2proc_tag  = 4'd5;
    bus.mem2proc_data = 64'h00c00113_00a00093;
    tick();
    bus.mem2proc_tag = 4'd0;
    #1;
    checks++;
    if (bus.Icache2buff_valid !== 3'b111 || bus.Icache2buff_hit_count !== 3'd3 ||
        bus.Icache2buff_data[2] !== 32'h00a00093) begin
      errors++; $display("FAIL busy_fill got %b/%0d data2 %h want 111/3 00a00093",
                         bus.Icache2buff_valid, bus.Icache2buff_hit_count,
                         bus.Icache2buff_data[2]);
    end
  endtask

  task automatic test_prefix_clamp();
    reset_dut();
    fill_line(32'h10, 64'h0000aaaa_0000bbbb, 4'd1);
    fill_line(32'h0, 64'h00500093_00100013, 4'd2);
    bus.buff2Icache_addr  = 32'h4;
    bus.buff2Icache_count = 3'd7;
    #1;
    checks++;
    if (bus.Icache2buff_valid !== 3'b001 || bus.Icache2buff_hit_count !== 3'd1) begin
      errors++; $display("FAIL prefix_valid got %b/%0d want 001/1",
                         bus.Icache2buff_valid, bus.Icache2buff_hit_count);
    end
    checks++;
    if (bus.Icache2buff_data[0] !== 32'h00500093 || bus.Icache2buff_data[1] !== 32'h0 ||
        bus.Icache2buff_addr[1] !== 32'h8) begin
      errors++; $display("FAIL prefix_data got %h %h addr1 %h want 00500093 0 8",
                         bus.Icache2buff_data[0], bus.Icache2buff_data[1],
                         bus.Icache2buff_addr[1]);
    end
    tick();
    checks++;
    if (bus.proc2mem_command !== 2'd1 || bus.proc2mem_addr !== 32'h8) begin
      errors++; $display("FAIL prefix_miss got cmd %0d addr %h want 1 8",
                         bus.proc2mem_command, bus.proc2mem_addr);
    end
  endtask

  task automatic test_conflict_eviction();
    reset_dut();
    fill_line(32'h0, 64'h11111111_01010101, 4'd3);
    #1;
    checks++;
    if (bus.Icache2buff_valid !== 3'b001 || bus.Icache2buff_data[0] !== 32'h01010101) begin
      errors++; $display("FAIL evict_first got %b %h want 001 01010101",
                         bus.Icache2buff_valid, bus.Icache2buff_data[0]);
    end
    fill_line(32'h100, 64'h22222222_33333333, 4'd4);
    #1;
    checks++;
    if (bus.Icache2buff_valid !== 3'b001 || bus.Icache2buff_data[0] !== 32'h33333333) begin
      errors++; $display("FAIL evict_second got %b %h want 001 33333333",
                         bus.Icache2buff_valid, bus.Icache2buff_data[0]);
    end
    bus.buff2Icache_addr = 32'h0;
    #1;
    checks++;
    if (bus.Icache2buff_valid !== 3'b000 || bus.Icache2buff_hit_count !== 3'd0) begin
      errors++; $display("FAIL evict_miss got %b/%0d want 000/0",
                         bus.Icache2buff_valid, bus.Icache2buff_hit_count);
    end
    tick();
    checks++;
    if (bus.proc2mem_command !== 2'd1 || bus.proc2mem_addr !== 32'h0) begin
      errors++; $display("FAIL evict_refetch got cmd %0d addr %h want 1 0",
                         bus.proc2mem_command, bus.proc2mem_addr);
    end
  endtask

  task automatic test_reset_mid_wait();
    reset_dut();
    bus.buff2Icache_addr  = 32'h0;
    bus.buff2Icache_count = 3'd1;
    tick();
    bus.mem2proc_response = 4'd9;
    tick();
    bus.mem2proc_response = 4'd0;
    checks++;
    if (bus.proc2mem_command !== 2'd0) begin
      errors++; $display("FAIL midwait_in_wait got cmd %0d want 0", bus.proc2mem_command);
    end
    reset = 1'b0;
    bus.buff2Icache_count = 3'd0;
    tick();
    reset = 1'b1;
    bus.mem2proc_tag  = 4'd9;
    bus.mem2proc_data = 64'h44444444_55555555;
    tick();
    tick();
    bus.mem2proc_tag      = 4'd0;
    bus.buff2Icache_count = 3'd1;
    #1;
    checks++;
    if (bus.Icache2buff_valid !== 3'b000 || bus.proc2mem_command !== 2'd0) begin
      errors++; $display("FAIL midwait_no_fill got valid %b cmd %0d want 000 0",
                         bus.Icache2buff_valid, bus.proc2mem_command);
    end
  endtask

  task automatic test_wrap();
    bus.buff2Icache_addr  = 32'hffff_fff8;
    bus.buff2Icache_count = 3'd3;
    #1;
    checks++;
    if (bus.Icache2buff_addr[0] !== 32'hffff_fff8 || bus.Icache2buff_addr[1] !== 32'hffff_fffc ||
        bus.Icache2buff_addr[2] !== 32'h0) begin
      errors++; $display("FAIL wrap_addr got %h %h %h want fffffff8 fffffffc 00000000",
                         bus.Icache2buff_addr[0], bus.Icache2buff_addr[1],
                         bus.Icache2buff_addr[2]);
    end
  endtask

  initial begin
    checks                = 0;
    errors                = 0;
    reset                 = 1'b0;
    bus.buff2Icache_addr  = 32'h0;
    bus.buff2Icache_count = 3'd0;
    bus.mem2proc_response = 4'd0;
    bus.mem2proc_data     = 64'h0;
    bus.mem2proc_tag      = 4'd0;
    test_reset();
    test_cold_fill();
    test_mem_busy();
    test_prefix_clamp();
    test_conflict_eviction();
    test_reset_mid_wait();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
